// File: rtl/tlb_cmd_arbiter_pkg.sv
// Shared TLB command types used by the TLB command arbiter and its requesters.
package tlb_cmd_arbiter_pkg;

   localparam int PAGE_INDEX_WIDTH = 20;
   localparam int ASID_WIDTH       = 8;

   typedef logic [PAGE_INDEX_WIDTH-1:0] page_index_t;

   typedef enum logic [1:0] {
      TLB_OP_UPDATE   = 2'd0,
      TLB_OP_INVAL    = 2'd1,
      TLB_OP_INVAL_ALL = 2'd2,
      TLB_OP_RSVD     = 2'd3
   } tlb_op_t;

   typedef struct packed {
      logic present;
      logic exe_writable;
      logic supervisor;
      logic is_global;
   } tlb_flags_t;

endpackage

// File: rtl/tlb_cmd_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr_q; ptr_q moves past the winner on advance.
module tlb_cmd_arbiter_rr_arbiter #(
   parameter int NUM_REQUESTERS = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQUESTERS-1:0] req,
   input  logic                      advance,
   output logic [NUM_REQUESTERS-1:0] grant
);
   localparam int PW = $clog2(NUM_REQUESTERS);

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] idx, gidx;
   logic          found;

   // Index arithmetic wraps for free because NUM_REQUESTERS is a power of two.
   always_comb begin
      grant = '0;
      found = 1'b0;
      gidx  = '0;
      idx   = '0;
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
         idx = ptr_q + PW'(k);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            gidx       = idx;
            found      = 1'b1;
         end
      end
      ptr_d = (advance && found) ? gidx + PW'(1) : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/tlb_cmd_arbiter.sv
// Muxes pipeline lookups and round-robin maintenance requests onto a single TLB command port.
module tlb_cmd_arbiter
   import tlb_cmd_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS = 4,
   parameter int STARVE_LIMIT   = 8
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       lookup_req,
   input  page_index_t                                lookup_vpage_idx,
   input  logic [ASID_WIDTH-1:0]                      lookup_asid,
   output logic                                       lookup_stall,
   input  logic [NUM_REQUESTERS-1:0]                  maint_valid,
   input  tlb_op_t [NUM_REQUESTERS-1:0]               maint_op,
   input  page_index_t [NUM_REQUESTERS-1:0]           maint_vpage_idx,
   input  logic [NUM_REQUESTERS-1:0][ASID_WIDTH-1:0]  maint_asid,
   input  page_index_t [NUM_REQUESTERS-1:0]           maint_ppage_idx,
   input  tlb_flags_t [NUM_REQUESTERS-1:0]            maint_flags,
   output logic [NUM_REQUESTERS-1:0]                  maint_grant,
   output logic [NUM_REQUESTERS-1:0]                  maint_done,
   output logic                                       tlb_lookup_en,
   output logic                                       tlb_update_en,
   output logic                                       tlb_invalidate_en,
   output logic                                       tlb_invalidate_all_en,
   output page_index_t                                tlb_request_vpage_idx,
   output logic [ASID_WIDTH-1:0]                      tlb_request_asid,
   output page_index_t                                tlb_update_ppage_idx,
   output logic                                       tlb_update_present,
   output logic                                       tlb_update_exe_writable,
   output logic                                       tlb_update_supervisor,
   output logic                                       tlb_update_global
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0]             starve_cnt_q, starve_cnt_d;
   logic [NUM_REQUESTERS-1:0] done_q, done_d;
   logic [NUM_REQUESTERS-1:0] arb_grant;
   logic                      maint_any, maint_win, lookup_win;

   tlb_op_t                   sel_op;
   page_index_t               sel_vpage, sel_ppage;
   logic [ASID_WIDTH-1:0]     sel_asid;
   tlb_flags_t                sel_flags;

   tlb_cmd_arbiter_rr_arbiter #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_rr (
      .clk     (clk),
      .reset   (reset),
      .req     (maint_valid),
      .advance (maint_win),
      .grant   (arb_grant)
   );

   assign maint_any  = |maint_valid;
   assign maint_win  = !reset && maint_any &&
                       (!lookup_req || starve_cnt_q == SW'(STARVE_LIMIT));
   assign lookup_win = !reset && lookup_req && !maint_win;

   always_comb begin
      sel_op    = TLB_OP_RSVD;
      sel_vpage = '0;
      sel_asid  = '0;
      sel_ppage = '0;
      sel_flags = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         if (arb_grant[i]) begin
            sel_op    = maint_op[i];
            sel_vpage = maint_vpage_idx[i];
            sel_asid  = maint_asid[i];
            sel_ppage = maint_ppage_idx[i];
            sel_flags = maint_flags[i];
         end
      end
   end

   always_comb begin
      tlb_lookup_en           = 1'b0;
      tlb_update_en           = 1'b0;
      tlb_invalidate_en       = 1'b0;
      tlb_invalidate_all_en   = 1'b0;
      tlb_request_vpage_idx   = '0;
      tlb_request_asid        = '0;
      tlb_update_ppage_idx    = '0;
      tlb_update_present      = 1'b0;
      tlb_update_exe_writable = 1'b0;
      tlb_update_supervisor   = 1'b0;
      tlb_update_global       = 1'b0;
      maint_grant             = maint_win ? arb_grant : '0;
      if (lookup_win) begin
         tlb_lookup_en         = 1'b1;
         tlb_request_vpage_idx = lookup_vpage_idx;
         tlb_request_asid      = lookup_asid;
      end else if (maint_win) begin
         // Reserved ops are still granted and completed, but touch nothing.
         unique case (sel_op)
            TLB_OP_UPDATE: begin
               tlb_update_en           = 1'b1;
               tlb_request_vpage_idx   = sel_vpage;
               tlb_request_asid        = sel_asid;
               tlb_update_ppage_idx    = sel_ppage;
               tlb_update_present      = sel_flags.present;
               tlb_update_exe_writable = sel_flags.exe_writable;
               tlb_update_supervisor   = sel_flags.supervisor;
               tlb_update_global       = sel_flags.is_global;
            end
            TLB_OP_INVAL: begin
               tlb_invalidate_en     = 1'b1;
               tlb_request_vpage_idx = sel_vpage;
               tlb_request_asid      = sel_asid;
            end
            TLB_OP_INVAL_ALL: tlb_invalidate_all_en = 1'b1;
            default: ;
         endcase
      end
   end

   assign lookup_stall = lookup_req && !tlb_lookup_en;

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!maint_any || maint_win)
         starve_cnt_d = '0;
      else if (starve_cnt_q != SW'(STARVE_LIMIT))
         starve_cnt_d = starve_cnt_q + SW'(1);
      done_d = maint_grant;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_q <= '0;
         done_q       <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         done_q       <= done_d;
      end
   end

   // Gating with reset drops a completion whose grant landed just before reset.
   assign maint_done = reset ? '0 : done_q;

   always_ff @(posedge clk) begin
      if (!reset)
         assert ($onehot0({tlb_lookup_en, tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en}));
   end

endmodule

// File: tb/tb_tlb_cmd_arbiter.sv
// Directed bench for tlb_cmd_arbiter with a queue scoreboard for maint_done.
module tb_tlb_cmd_arbiter;
   import tlb_cmd_arbiter_pkg::*;

   localparam logic [3:0] C_NO = 4'b0000, C_LK = 4'b1000, C_UP = 4'b0100,
                          C_IN = 4'b0010, C_IA = 4'b0001;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       lookup_req;
   page_index_t                lookup_vpage_idx;
   logic [ASID_WIDTH-1:0]      lookup_asid;
   logic                       lookup_stall;
   logic [3:0]                 maint_valid;
   tlb_op_t [3:0]              maint_op;
   page_index_t [3:0]          maint_vpage_idx;
   logic [3:0][ASID_WIDTH-1:0] maint_asid;
   page_index_t [3:0]          maint_ppage_idx;
   tlb_flags_t [3:0]           maint_flags;
   logic [3:0]                 maint_grant, maint_done;
   logic                       tlb_lookup_en, tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en;
   page_index_t                tlb_request_vpage_idx, tlb_update_ppage_idx;
   logic [ASID_WIDTH-1:0]      tlb_request_asid;
   logic                       tlb_update_present, tlb_update_exe_writable;
   logic                       tlb_update_supervisor, tlb_update_global;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [3:0] cmd;
      logic [3:0] grant;
      logic       stall;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] done_sb[$];

   always #5 clk = ~clk;

   tlb_cmd_arbiter #(.NUM_REQUESTERS(4), .STARVE_LIMIT(8)) dut (
      .clk                     (clk),
      .reset                   (rst),
      .lookup_req              (lookup_req),
      .lookup_vpage_idx        (lookup_vpage_idx),
      .lookup_asid             (lookup_asid),
      .lookup_stall            (lookup_stall),
      .maint_valid             (maint_valid),
      .maint_op                (maint_op),
      .maint_vpage_idx         (maint_vpage_idx),
      .maint_asid              (maint_asid),
      .maint_ppage_idx         (maint_ppage_idx),
      .maint_flags             (maint_flags),
      .maint_grant             (maint_grant),
      .maint_done              (maint_done),
      .tlb_lookup_en           (tlb_lookup_en),
      .tlb_update_en           (tlb_update_en),
      .tlb_invalidate_en       (tlb_invalidate_en),
      .tlb_invalidate_all_en   (tlb_invalidate_all_en),
      .tlb_request_vpage_idx   (tlb_request_vpage_idx),
      .tlb_request_asid        (tlb_request_asid),
      .tlb_update_ppage_idx    (tlb_update_ppage_idx),
      .tlb_update_present      (tlb_update_present),
      .tlb_update_exe_writable (tlb_update_exe_writable),
      .tlb_update_supervisor   (tlb_update_supervisor),
      .tlb_update_global       (tlb_update_global)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are set at the falling edge; outputs are sampled 2 time units later.
   task automatic step(input string tag, input logic [3:0] cmd, input logic [3:0] grant, input logic stall);
      exp_t       e;
      logic [3:0] e_done;
      exp_q.push_back('{cmd: cmd, grant: grant, stall: stall});
      done_sb.push_back(rst ? 4'b0000 : grant);
      #2;
      e      = exp_q.pop_front();
      e_done = done_sb.pop_front();
      if (rst) e_done = 4'b0000;
      chk({tag, "_cmd"}, {28'd0, tlb_lookup_en, tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en}, {28'd0, e.cmd});
      chk({tag, "_grant"}, {28'd0, maint_grant}, {28'd0, e.grant});
      chk({tag, "_stall"}, {31'd0, lookup_stall}, {31'd0, e.stall});
      chk({tag, "_done"}, {28'd0, maint_done}, {28'd0, e_done});
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic cyc(input string tag, input logic [3:0] cmd, input logic [3:0] grant, input logic stall);
      step(tag, cmd, grant, stall);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      lookup_req = 1'b1;
      lookup_vpage_idx = 20'h00100;
      lookup_asid = 8'h01;
      maint_valid = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         maint_op[i]        = TLB_OP_INVAL;
         maint_vpage_idx[i] = page_index_t'(20'h00010 * (i + 1));
         maint_asid[i]      = 8'(8'h10 + i);
         maint_ppage_idx[i] = '0;
         maint_flags[i]     = '0;
      end
      done_sb.push_back(4'b0000);

      cyc("rst0", C_NO, 4'b0000, 1'b1);
      cyc("rst1", C_NO, 4'b0000, 1'b1);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         lookup_vpage_idx = page_index_t'(20'h00200 + i);
         step("lookup", C_LK, 4'b0000, 1'b0);
         if (i == 3) chk("lookup_vpage", 32'(tlb_request_vpage_idx), 32'h00203);
         tick();
      end

      // Fill from requester 0, then a lookup of the same page.
      lookup_req = 1'b0;
      maint_valid = 4'b0001;
      maint_op[0] = TLB_OP_UPDATE;
      maint_vpage_idx[0] = 20'h12345;
      maint_asid[0] = 8'h05;
      maint_ppage_idx[0] = 20'h00ABC;
      maint_flags[0] = '{present: 1'b1, exe_writable: 1'b0, supervisor: 1'b1, is_global: 1'b0};
      step("upd", C_UP, 4'b0001, 1'b0);
      chk("upd_vpage", 32'(tlb_request_vpage_idx), 32'h12345);
      chk("upd_ppage", 32'(tlb_update_ppage_idx), 32'h00ABC);
      chk("upd_asid", 32'(tlb_request_asid), 32'h05);
      chk("upd_flags", {28'd0, tlb_update_present, tlb_update_exe_writable, tlb_update_supervisor, tlb_update_global}, 32'hA);
      tick();
      maint_valid = 4'b0000;
      lookup_req = 1'b1;
      lookup_vpage_idx = 20'h12345;
      step("lk_after_upd", C_LK, 4'b0000, 1'b0);
      chk("lk_after_upd_vpage", 32'(tlb_request_vpage_idx), 32'h12345);
      tick();

      // Grant then reset: the completion must be dropped and the pointer cleared.
      lookup_req = 1'b0;
      maint_valid = 4'b0001;
      cyc("pre_rst_grant", C_UP, 4'b0001, 1'b0);
      maint_valid = 4'b0000;
      rst = 1'b1;
      cyc("rst_mid", C_NO, 4'b0000, 1'b0);
      rst = 1'b0;
      cyc("post_rst", C_NO, 4'b0000, 1'b0);

      // All four pending: rotation starts at 0 after reset and wraps.
      maint_op[0] = TLB_OP_INVAL;
      maint_vpage_idx[0] = 20'h00010;
      maint_valid = 4'b1111;
      begin
         logic [3:0] rot [5];
         rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
         for (int i = 0; i < 5; i++) begin
            step("rr_rot", C_IN, rot[i], 1'b0);
            chk("rr_vpage", 32'(tlb_request_vpage_idx), 32'h10 * ((i % 4) + 1));
            tick();
         end
      end
      maint_valid = 4'b0010;
      cyc("rr_to2", C_IN, 4'b0010, 1'b0);
      maint_valid = 4'b0001;
      cyc("rr_wrap0", C_IN, 4'b0001, 1'b0);
      maint_valid = 4'b0011;
      cyc("rr_ptr1", C_IN, 4'b0010, 1'b0);

      // Starvation: requester 2 held against continuous lookups, twice.
      lookup_req = 1'b1;
      maint_valid = 4'b0100;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 8; i++) cyc("starve_lk", C_LK, 4'b0000, 1'b0);
         step("starve_force", C_IN, 4'b0100, 1'b1);
         chk("starve_force_vpage", 32'(tlb_request_vpage_idx), 32'h30);
         tick();
      end
      maint_valid = 4'b0000;
      cyc("post_force", C_LK, 4'b0000, 1'b0);

      // Invalidate-all on 1 and update on 3; pointer sits at 3.
      lookup_req = 1'b0;
      maint_op[1] = TLB_OP_INVAL_ALL;
      maint_vpage_idx[1] = 20'hFFFFF;
      maint_asid[1] = 8'hFF;
      maint_op[3] = TLB_OP_UPDATE;
      maint_vpage_idx[3] = 20'h0BEEF;
      maint_ppage_idx[3] = 20'h0CAFE;
      maint_valid = 4'b1010;
      step("mix_upd", C_UP, 4'b1000, 1'b0);
      chk("mix_upd_ppage", 32'(tlb_update_ppage_idx), 32'h0CAFE);
      tick();
      maint_valid = 4'b0010;
      step("mix_iall", C_IA, 4'b0010, 1'b0);
      chk("iall_vpage", 32'(tlb_request_vpage_idx), 32'h0);
      chk("iall_asid", 32'(tlb_request_asid), 32'h0);
      tick();
      maint_valid = 4'b0000;
      cyc("mix_idle", C_NO, 4'b0000, 1'b0);

      // Reserved op: granted and completed, no strobe.
      maint_op[0] = TLB_OP_RSVD;
      maint_valid = 4'b0001;
      cyc("rsvd", C_NO, 4'b0001, 1'b0);
      maint_valid = 4'b0000;
      lookup_req = 1'b1;
      cyc("rsvd_done", C_LK, 4'b0000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/tlb_cmd_arbiter.md
Name: tlb_cmd_arbiter

Overview:
- Shares one tlb instance between the pipeline lookup port and NUM_REQUESTERS maintenance requesters (per-thread TLB fill, invalidate and invalidate-all control-register writes).
- Issues at most one one-hot command per cycle: lookup_en, update_en, invalidate_en or invalidate_all_en.
- Grants maintenance round-robin, with bounded starvation against pipeline lookups.
- Reports per-requester completion aligned with the cycle in which the TLB write lands.

Parameters:
NUM_REQUESTERS, 4, number of maintenance requesters (power of two, >= 2)
STARVE_LIMIT, 8, consecutive cycles a pending maintenance request may lose to lookups before it is forced (>= 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
lookup_req  in  1  pipeline requests a lookup this cycle
lookup_vpage_idx  in  page_index_t  lookup virtual page
lookup_asid  in  ASID_WIDTH  lookup address space ID
lookup_stall  out  1  lookup_req was not issued this cycle; pipeline must replay it
maint_valid  in  NUM_REQUESTERS  maintenance request pending, held until granted
maint_op  in  tlb_op_t[NUM_REQUESTERS]  TLB_OP_UPDATE / TLB_OP_INVAL / TLB_OP_INVAL_ALL
maint_vpage_idx  in  page_index_t[NUM_REQUESTERS]  target virtual page
maint_asid  in  ASID_WIDTH[NUM_REQUESTERS]  target address space ID
maint_ppage_idx  in  page_index_t[NUM_REQUESTERS]  fill physical page
maint_flags  in  tlb_flags_t[NUM_REQUESTERS]  present, exe_writable, supervisor, global
maint_grant  out  NUM_REQUESTERS  one-hot: request accepted this cycle
maint_done  out  NUM_REQUESTERS  one-hot pulse: command committed in TLB
tlb_lookup_en, tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en  out  1 each  TLB command strobes, at most one high
tlb_request_vpage_idx  out  page_index_t  to TLB
tlb_request_asid  out  ASID_WIDTH  to TLB
tlb_update_ppage_idx  out  page_index_t  to TLB
tlb_update_present, tlb_update_exe_writable, tlb_update_supervisor, tlb_update_global  out  1 each  to TLB

Behaviour:
- Command outputs are combinational from the current inputs and state; the TLB latches them itself. Lookup results come straight from the TLB one cycle later and do not pass through this block.
- Per-cycle slot decision:
  - No maint_valid: issue the lookup if lookup_req.
  - Maintenance pending and no lookup_req: maintenance wins.
  - Both pending: lookup wins unless starve_cnt == STARVE_LIMIT, in which case maintenance wins.
- Maintenance selection: round-robin starting at rr_ptr. On a grant to requester i, rr_ptr <= (i+1) mod NUM_REQUESTERS; wrap-around from the last index to 0 is required.
- Granted request drives tlb_request_* from that requester's fields, asserts the strobe selected by maint_op, and pulses maint_grant[i]. The requester may drop maint_valid the next cycle.
- INVAL_ALL ignores the vpage/asid fields; they are driven as 0.
- lookup_stall = lookup_req and not tlb_lookup_en.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle where maintenance is pending and lookup wins.
  - Clears on any maintenance grant, or when no maintenance is pending.
- maint_done[i] is registered: it pulses exactly 1 cycle after maint_grant[i], the cycle the TLB stage-2 write or invalidate-all clear takes effect.
- Back-to-back maintenance grants on consecutive cycles are legal: the TLB bypass covers a same-set read/write. A lookup in the cycle after an update sees the new entry.
- An illegal maint_op value is treated as a no-op. It is still granted and done, and no strobe is asserted.
- Reset values: all strobes 0, maint_grant 0, maint_done 0, lookup_stall = lookup_req, rr_ptr 0, starve_cnt 0.
- Reset asserted mid-operation suppresses any pending maint_done pulse.
- Assertion: the four tlb_*_en outputs are $onehot0 every cycle.

Decomposition:
- defines.sv additions: tlb_op_t enum (2 bits: UPDATE, INVAL, INVAL_ALL, reserved) and tlb_flags_t packed struct {present, exe_writable, supervisor, global}.
- page_index_t and ASID_WIDTH are already shared.
- One sub-module is natural: rr_arbiter (NUM_REQUESTERS, request vector, advance strobe, one-hot grant, internal pointer). It is reusable for other shared resources.

Test Plan:
- Reset, then lookup_req=1 with no maintenance for 10 cycles -> tlb_lookup_en=1 every cycle, lookup_stall=0, maint_done=0.
- maint_valid=4'b0001, op UPDATE, vpage 0x12345, ppage 0x00ABC, lookup_req=0 -> tlb_update_en=1 and maint_grant=0001 in cycle 0, maint_done=0001 in cycle 1. A following lookup of 0x12345 hits with ppage 0x00ABC.
- maint_valid=4'b1111 held, no lookups -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles. With rr_ptr=2 and only requester 0 pending -> grant 0001 and rr_ptr becomes 1.
- lookup_req=1 continuously with requester 2 INVAL pending, STARVE_LIMIT=8 -> 8 cycles of lookup issue, then in cycle 8 tlb_invalidate_en=1, maint_grant=0100, lookup_stall=1; starve_cnt returns to 0.
- Requester 1 INVAL_ALL while requester 3 UPDATE pending -> two consecutive single-strobe cycles in round-robin order; maint_done pulses follow each grant by one cycle; $onehot0 never violated.
- Reset asserted in the cycle after a grant -> maint_done stays 0, rr_ptr=0, starve_cnt=0 next cycle.
